// File: rtl/param_full_adder_pkg.sv
// Shared arithmetic constants for the ripple-carry adder family.
// Operand widths outside [ADDER_MIN_WIDTH, ADDER_MAX_WIDTH] are not supported.
package param_full_adder_pkg;

   localparam int unsigned ADDER_DEFAULT_WIDTH = 4;
   localparam int unsigned ADDER_MIN_WIDTH     = 1;
   localparam int unsigned ADDER_MAX_WIDTH     = 64;

   typedef struct packed {
      logic s;
      logic cout;
   } fa_out_t;

   // Reference one-bit full adder, shared by the bit cell.
   function automatic fa_out_t fa_eval(input logic a, input logic b, input logic cin);
      fa_out_t r;
      logic    p;
      p      = a ^ b;
      r.s    = p ^ cin;
      r.cout = (a & b) | (cin & p);
      return r;
   endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One-bit combinational full adder: one stage of the ripple-carry chain.
module full_adder_bit
   import param_full_adder_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   fa_out_t r;

   always_comb begin
      r    = fa_eval(a, b, cin);
      s    = r.s;
      cout = r.cout;
   end

endmodule

// File: rtl/param_full_adder.sv
// WIDTH-bit ripple-carry adder with registered sum and carry-out (one cycle latency).
// X/Z on inputs is deliberately not masked and propagates to the outputs.
module param_full_adder
   import param_full_adder_pkg::*;
#(
   parameter int unsigned WIDTH = ADDER_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] s_d, s_q;
   logic             cout_d, cout_q;

   assign c[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      full_adder_bit u_bit (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (c[i]),
         .s    (sum[i]),
         .cout (c[i+1])
      );
   end

   always_comb begin
      s_d    = sum;
      cout_d = c[WIDTH];
   end

   // Reset wins over new data, so an in-flight result is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_q    <= '0;
         cout_q <= 1'b0;
      end else begin
         s_q    <= s_d;
         cout_q <= cout_d;
      end
   end

   assign s    = s_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_param_full_adder.sv
// Directed and random checks of param_full_adder at widths 1, 4, 8, 16 and 32.
module tb_param_full_adder;

   logic clk = 1'b0;
   logic rst;

   logic [0:0]  a1,  b1,  s1;
   logic [3:0]  a4,  b4,  s4;
   logic [7:0]  a8,  b8,  s8;
   logic [15:0] a16, b16, s16;
   logic [31:0] a32, b32, s32;
   logic cin1, cin4, cin8, cin16, cin32;
   logic cout1, cout4, cout8, cout16, cout32;

   int n_checks = 0;
   int n_fail   = 0;

   logic [64:0] e1, e4, e8, e16, e32;

   always #5 clk = ~clk;

   param_full_adder #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1), .s(s1), .cout(cout1));
   param_full_adder #(.WIDTH(4)) u_w4 (
      .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4), .s(s4), .cout(cout4));
   param_full_adder #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8), .s(s8), .cout(cout8));
   param_full_adder #(.WIDTH(16)) u_w16 (
      .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin16), .s(s16), .cout(cout16));
   param_full_adder #(.WIDTH(32)) u_w32 (
      .clk(clk), .rst(rst), .a(a32), .b(b32), .cin(cin32), .s(s32), .cout(cout32));

   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed {cout,s}=%h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      a1 = '0;  b1 = '0;  cin1 = 1'b0;
      a4 = 4'd9; b4 = 4'd9; cin4 = 1'b1;
      a8 = '0;  b8 = '0;  cin8 = 1'b0;
      a16 = '0; b16 = '0; cin16 = 1'b0;
      a32 = '0; b32 = '0; cin32 = 1'b0;

      // Reset held for two edges with live operands on the inputs
      tick();
      chk("reset_edge1_w4", 65'({cout4, s4}), 65'd0);
      chk("reset_edge1_w32", 65'({cout32, s32}), 65'd0);
      tick();
      chk("reset_edge2_w4", 65'({cout4, s4}), 65'd0);
      chk("reset_edge2_w1", 65'({cout1, s1}), 65'd0);
      rst = 1'b0;
      tick();
      chk("after_reset_9_9_1", 65'({cout4, s4}), 65'h13);

      // Carry ripple through all four bits
      a4 = 4'd15; b4 = 4'd0; cin4 = 1'b1;
      tick();
      chk("ripple_15_0_1", 65'({cout4, s4}), 65'h10);
      a4 = 4'd7; b4 = 4'd8; cin4 = 1'b0;
      tick();
      chk("no_carry_7_8_0", 65'({cout4, s4}), 65'h0F);

      // Back-to-back operations on consecutive edges
      a4 = 4'd3; b4 = 4'd4; cin4 = 1'b0;
      tick();
      chk("b2b_3_4_0", 65'({cout4, s4}), 65'h07);
      a4 = 4'd15; b4 = 4'd15; cin4 = 1'b1;
      tick();
      chk("b2b_max_w4", 65'({cout4, s4}), 65'h1F);
      a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0;
      tick();
      chk("b2b_zero", 65'({cout4, s4}), 65'h00);

      // Width 8 override
      a8 = 8'd200; b8 = 8'd100; cin8 = 1'b1;
      tick();
      chk("w8_200_100_1", 65'({cout8, s8}), 65'h12D);
      a8 = 8'd255; b8 = 8'd255; cin8 = 1'b1;
      tick();
      chk("w8_max", 65'({cout8, s8}), 65'h1FF);

      // Width 16/32 boundary: all-ones plus carry-in
      a16 = 16'hFFFF; b16 = 16'h0000; cin16 = 1'b1;
      a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; cin32 = 1'b1;
      tick();
      chk("w16_ripple", 65'({cout16, s16}), 65'h1_0000);
      chk("w32_max", 65'({cout32, s32}), 65'h1_FFFF_FFFF);

      // Reset mid-stream discards the in-flight result
      a4 = 4'd5; b4 = 4'd6; cin4 = 1'b0;
      rst = 1'b1;
      tick();
      chk("midstream_reset", 65'({cout4, s4}), 65'd0);
      rst = 1'b0;
      tick();
      chk("post_midstream", 65'({cout4, s4}), 65'h0B);

      // Width 1: all eight input combinations, hand-computed sums
      a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; tick(); chk("w1_000", 65'({cout1, s1}), 65'd0);
      a1 = 1'b0; b1 = 1'b0; cin1 = 1'b1; tick(); chk("w1_001", 65'({cout1, s1}), 65'd1);
      a1 = 1'b0; b1 = 1'b1; cin1 = 1'b0; tick(); chk("w1_010", 65'({cout1, s1}), 65'd1);
      a1 = 1'b0; b1 = 1'b1; cin1 = 1'b1; tick(); chk("w1_011", 65'({cout1, s1}), 65'd2);
      a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0; tick(); chk("w1_100", 65'({cout1, s1}), 65'd1);
      a1 = 1'b1; b1 = 1'b0; cin1 = 1'b1; tick(); chk("w1_101", 65'({cout1, s1}), 65'd2);
      a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0; tick(); chk("w1_110", 65'({cout1, s1}), 65'd2);
      a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; tick(); chk("w1_111", 65'({cout1, s1}), 65'd3);

      // Random operands on every width each cycle, expected sum at WIDTH+1 bits
      for (int i = 0; i < 24; i++) begin
         a1  = 1'($urandom);  b1  = 1'($urandom);  cin1  = 1'($urandom);
         a4  = 4'($urandom);  b4  = 4'($urandom);  cin4  = 1'($urandom);
         a8  = 8'($urandom);  b8  = 8'($urandom);  cin8  = 1'($urandom);
         a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
         a32 = $urandom;      b32 = $urandom;      cin32 = 1'($urandom);
         e1  = 65'(a1)  + 65'(b1)  + 65'(cin1);
         e4  = 65'(a4)  + 65'(b4)  + 65'(cin4);
         e8  = 65'(a8)  + 65'(b8)  + 65'(cin8);
         e16 = 65'(a16) + 65'(b16) + 65'(cin16);
         e32 = 65'(a32) + 65'(b32) + 65'(cin32);
         tick();
         chk("rand_w1",  65'({cout1, s1}),   e1);
         chk("rand_w4",  65'({cout4, s4}),   e4);
         chk("rand_w8",  65'({cout8, s8}),   e8);
         chk("rand_w16", 65'({cout16, s16}), e16);
         chk("rand_w32", 65'({cout32, s32}), e32);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
